tb_quiesce_monitor: RTL and testbench
=====================================

// Module: tb_quiesce_monitor
//
// PURPOSE
//   Testbench-side monitor that drives the `idle` input of the sim-control module.
//   - Taps AXI handshake fires on every DUT memory port.
//   - Counts outstanding read and write transactions per port.
//   - Asserts `idle` only after all ports have been quiet for a programmable window.
//   - Flags protocol-accounting errors (completion without issue, counter overflow).
//     On error, `idle` is suppressed, so the sim controller's quit-timeout fires.
//
// PARAMETERS
//   NUM_PORTS    4   number of monitored AXI ports (>=1)
//   CNT_W        8   width of each per-port outstanding counter (read and write separate)
//   IDLE_CYCLES  16  consecutive quiet cycles required before idle asserts (>=1)
//
// PORTS
//   clock          in   1                    sim clock
//   reset_n        in   1                    asynchronous, active-low reset
//   init_flag      in   1                    high during init; synchronous clear of all state
//   ar_fire        in   NUM_PORTS            arvalid&arready per port
//   r_last_fire    in   NUM_PORTS            rvalid&rready&rlast per port
//   aw_fire        in   NUM_PORTS            awvalid&awready per port
//   b_fire         in   NUM_PORTS            bvalid&bready per port
//   idle           out  1                    all ports quiescent for IDLE_CYCLES, no error
//   outstanding    out  CNT_W+$clog2(2*NUM_PORTS+1)  sum of all rd+wr counters (registered)
//   error          out  1                    sticky accounting error
//   err_port       out  max(1,$clog2(NUM_PORTS))     lowest port index of the first error
//
// BEHAVIOUR
//   Reset values: reset_n low -> all counters 0, state BUSY, settle_cnt 0.
//     Outputs: idle=0, outstanding=0, error=0, err_port=0.
//   init_flag=1 at a clock edge: same clear as reset. Takes priority over all fire inputs.
//   Read counter rd[p], evaluated each edge:
//     - +1 on ar_fire[p]; -1 on r_last_fire[p]; both in the same cycle -> unchanged.
//     - Underflow: r_last_fire with rd==0 and no ar_fire -> rd stays 0, error event.
//     - Overflow: ar_fire with rd==all-ones and no r_last_fire -> rd saturates, error event.
//   Write counter wr[p]: identical rules using aw_fire / b_fire.
//   Error events:
//     - error latches 1 and holds until reset or init_flag.
//     - err_port captures the lowest port with an event in the first erroring cycle only.
//   outstanding: registered sum of post-update counters. Same cycle as the counters.
//   quiet_c (combinational) = all rd/wr registers ==0 AND no fire input asserted this cycle.
//   FSM, per clock edge:
//     BUSY:   quiet_c && IDLE_CYCLES==1 -> IDLE
//             quiet_c                   -> SETTLE, settle_cnt=1
//             else                      -> stay BUSY
//     SETTLE: !quiet_c                  -> BUSY, settle_cnt=0
//             settle_cnt==IDLE_CYCLES-1 -> IDLE
//             else                      -> settle_cnt++
//     IDLE:   !quiet_c                  -> BUSY, settle_cnt=0
//   idle = (state==IDLE) && !error. Registered, no combinational path from inputs.
//   Latency: idle rises on the IDLE_CYCLES-th consecutive quiet edge.
//     It falls on the first edge where a fire is seen.
//   Fires in IDLE drop idle even if they net to zero. A new request always breaks quiescence.
//   Reset mid-operation: asynchronous clear, with no residual settle count.
//
// TESTING
//   1. Reset, 20 quiet cycles, IDLE_CYCLES=16 -> idle=0 through edge 15, idle=1 from edge 16.
//   2. Port0: ar_fire once, r_last_fire 5 cycles later -> outstanding 1 then 0.
//      idle=1 exactly 16 edges after the r_last_fire edge.
//   3. Port2: b_fire with wr[2]==0 -> error=1, err_port=2, idle forced 0 permanently.
//      init_flag pulse clears error.
//   4. Port1: aw_fire and b_fire in the same cycle with wr[1]=3 -> wr[1] stays 3, no error.
//      Simultaneous underflow on ports 3 and 1 -> err_port=1.
//   5. In IDLE, a single ar_fire+r_last_fire pair in one cycle -> idle drops next edge.
//      It re-asserts after 16 further quiet edges.
//   6. CNT_W=2: four ar_fire on port0 -> rd saturates at 3, error=1.
//      Also: assert reset_n low mid-SETTLE -> idle=0, outstanding=0 asynchronously.

Source files
------------

// File: rtl/tb_quiesce_monitor.sv
// Quiescence monitor: tracks outstanding AXI read/write transactions per port and
// raises idle once every port has stayed quiet for IDLE_CYCLES consecutive edges.
module tb_quiesce_monitor #(
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned IDLE_CYCLES = 16,
    localparam int unsigned OUT_W      = CNT_W + $clog2(2 * NUM_PORTS + 1),
    localparam int unsigned EP_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 init_flag,
    input  logic [NUM_PORTS-1:0] ar_fire,
    input  logic [NUM_PORTS-1:0] r_last_fire,
    input  logic [NUM_PORTS-1:0] aw_fire,
    input  logic [NUM_PORTS-1:0] b_fire,
    output logic                 idle,
    output logic [OUT_W-1:0]     outstanding,
    output logic                 error,
    output logic [EP_W-1:0]      err_port
);

    localparam int unsigned SC_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_BUSY,
        S_SETTLE,
        S_IDLE
    } state_t;

    state_t               state_q, state_d;
    logic [SC_W-1:0]      settle_q, settle_d;
    logic [CNT_W-1:0]     rd_q [NUM_PORTS];
    logic [CNT_W-1:0]     wr_q [NUM_PORTS];
    logic [CNT_W-1:0]     rd_d [NUM_PORTS];
    logic [CNT_W-1:0]     wr_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] ev;
    logic [EP_W-1:0]      ev_idx;
    logic [OUT_W-1:0]     sum_d;
    logic [OUT_W-1:0]     outstanding_q;
    logic                 error_q;
    logic [EP_W-1:0]      err_port_q;
    logic                 quiet_c;

    // Counter update: simultaneous issue/complete nets to zero; saturate and flag on
    // overflow or completion-without-issue.
    always_comb begin
        ev    = '0;
        sum_d = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            rd_d[p] = rd_q[p];
            wr_d[p] = wr_q[p];
            if (ar_fire[p] && !r_last_fire[p]) begin
                if (&rd_q[p]) ev[p] = 1'b1;
                else          rd_d[p] = rd_q[p] + 1'b1;
            end else if (!ar_fire[p] && r_last_fire[p]) begin
                if (rd_q[p] == '0) ev[p] = 1'b1;
                else               rd_d[p] = rd_q[p] - 1'b1;
            end
            if (aw_fire[p] && !b_fire[p]) begin
                if (&wr_q[p]) ev[p] = 1'b1;
                else          wr_d[p] = wr_q[p] + 1'b1;
            end else if (!aw_fire[p] && b_fire[p]) begin
                if (wr_q[p] == '0) ev[p] = 1'b1;
                else               wr_d[p] = wr_q[p] - 1'b1;
            end
            sum_d = sum_d + OUT_W'(rd_d[p]) + OUT_W'(wr_d[p]);
        end
    end

    always_comb begin
        ev_idx = '0;
        for (int unsigned i = NUM_PORTS; i > 0; i--) begin
            if (ev[i-1]) ev_idx = EP_W'(i - 1);
        end
    end

    always_comb begin
        quiet_c = ~|{ar_fire, r_last_fire, aw_fire, b_fire};
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (rd_q[p] != '0 || wr_q[p] != '0) quiet_c = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        case (state_q)
            S_BUSY: begin
                if (quiet_c) begin
                    if (IDLE_CYCLES == 1) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d  = S_SETTLE;
                        settle_d = SC_W'(1);
                    end
                end
            end
            S_SETTLE: begin
                if (!quiet_c) begin
                    state_d  = S_BUSY;
                    settle_d = '0;
                end else if (settle_q == SC_W'(IDLE_CYCLES - 1)) begin
                    state_d  = S_IDLE;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (!quiet_c) begin
                    state_d  = S_BUSY;
                    settle_d = '0;
                end
            end
            default: begin
                state_d  = S_BUSY;
                settle_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_BUSY;
            settle_q      <= '0;
            outstanding_q <= '0;
            error_q       <= 1'b0;
            err_port_q    <= '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                rd_q[p] <= '0;
                wr_q[p] <= '0;
            end
        end else if (init_flag) begin
            state_q       <= S_BUSY;
            settle_q      <= '0;
            outstanding_q <= '0;
            error_q       <= 1'b0;
            err_port_q    <= '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                rd_q[p] <= '0;
                wr_q[p] <= '0;
            end
        end else begin
            state_q       <= state_d;
            settle_q      <= settle_d;
            outstanding_q <= sum_d;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                rd_q[p] <= rd_d[p];
                wr_q[p] <= wr_d[p];
            end
            // Only the first erroring cycle records a port; later events are ignored.
            if ((|ev) && !error_q) begin
                error_q    <= 1'b1;
                err_port_q <= ev_idx;
            end
        end
    end

    assign idle        = (state_q == S_IDLE) && !error_q;
    assign outstanding = outstanding_q;
    assign error       = error_q;
    assign err_port    = err_port_q;

endmodule

// File: tb/tb_tb_quiesce_monitor.sv
// Directed self-checking bench for tb_quiesce_monitor (default build plus a
// CNT_W=2 build for saturation and asynchronous-reset checks).
module tb_tb_quiesce_monitor;

    logic        clock;
    logic        reset_n, init_flag;
    logic [3:0]  ar, rl, aw, b;
    logic        idle, error;
    logic [11:0] outstanding;
    logic [1:0]  err_port;

    logic        rst2_n, init2;
    logic [3:0]  ar2, zero4;
    logic        idle2, error2;
    logic [5:0]  outstanding2;
    logic [1:0]  err_port2;

    int tests = 0;
    int fails = 0;

    tb_quiesce_monitor #(.NUM_PORTS(4), .CNT_W(8), .IDLE_CYCLES(16)) dut (
        .clock(clock), .reset_n(reset_n), .init_flag(init_flag),
        .ar_fire(ar), .r_last_fire(rl), .aw_fire(aw), .b_fire(b),
        .idle(idle), .outstanding(outstanding), .error(error), .err_port(err_port)
    );

    tb_quiesce_monitor #(.NUM_PORTS(4), .CNT_W(2), .IDLE_CYCLES(16)) dut2 (
        .clock(clock), .reset_n(rst2_n), .init_flag(init2),
        .ar_fire(ar2), .r_last_fire(zero4), .aw_fire(zero4), .b_fire(zero4),
        .idle(idle2), .outstanding(outstanding2), .error(error2), .err_port(err_port2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; init_flag = 1'b0; ar = '0; rl = '0; aw = '0; b = '0;
        rst2_n = 1'b0; init2 = 1'b0; ar2 = '0; zero4 = '0;
        #12;
        chk("rst_idle", 32'(idle), 0);
        chk("rst_out", 32'(outstanding), 0);
        chk("rst_err", 32'(error), 0);
        chk("rst_errport", 32'(err_port), 0);
        reset_n = 1'b1; rst2_n = 1'b1;

        // 1: idle after exactly 16 quiet edges
        repeat (15) step();
        chk("t1_idle_e15", 32'(idle), 0);
        step();
        chk("t1_idle_e16", 32'(idle), 1);
        repeat (4) step();
        chk("t1_idle_e20", 32'(idle), 1);

        // 2: one read transaction on port 0
        ar[0] = 1'b1; step(); ar = '0;
        chk("t2_out_issue", 32'(outstanding), 1);
        chk("t2_idle_busy", 32'(idle), 0);
        repeat (4) step();
        chk("t2_out_hold", 32'(outstanding), 1);
        rl[0] = 1'b1; step(); rl = '0;
        chk("t2_out_done", 32'(outstanding), 0);
        repeat (15) step();
        chk("t2_idle_15", 32'(idle), 0);
        step();
        chk("t2_idle_16", 32'(idle), 1);

        // 3: write underflow on port 2, sticky error, init clears
        b[2] = 1'b1; step(); b = '0;
        chk("t3_err", 32'(error), 1);
        chk("t3_errport", 32'(err_port), 2);
        chk("t3_idle", 32'(idle), 0);
        chk("t3_out", 32'(outstanding), 0);
        rl[0] = 1'b1; step(); rl = '0;
        chk("t3_errport_first", 32'(err_port), 2);
        repeat (20) step();
        chk("t3_idle_suppr", 32'(idle), 0);
        chk("t3_err_sticky", 32'(error), 1);
        init_flag = 1'b1; ar[1] = 1'b1; step(); init_flag = 1'b0; ar = '0;
        chk("t3_init_err", 32'(error), 0);
        chk("t3_init_port", 32'(err_port), 0);
        chk("t3_init_out", 32'(outstanding), 0);

        // 4: net-zero write on port 1, then simultaneous underflow on ports 3 and 1
        aw[1] = 1'b1; repeat (3) step();
        chk("t4_out3", 32'(outstanding), 3);
        b[1] = 1'b1; step(); aw = '0; b = '0;
        chk("t4_out_same", 32'(outstanding), 3);
        chk("t4_noerr", 32'(error), 0);
        rl[3] = 1'b1; rl[1] = 1'b1; step(); rl = '0;
        chk("t4_err", 32'(error), 1);
        chk("t4_errport", 32'(err_port), 1);
        chk("t4_out_kept", 32'(outstanding), 3);
        init_flag = 1'b1; step(); init_flag = 1'b0;
        chk("t4_init_out", 32'(outstanding), 0);

        // 5: net-zero fire while idle breaks quiescence
        repeat (16) step();
        chk("t5_idle_pre", 32'(idle), 1);
        ar[0] = 1'b1; rl[0] = 1'b1; step(); ar = '0; rl = '0;
        chk("t5_idle_drop", 32'(idle), 0);
        chk("t5_out", 32'(outstanding), 0);
        chk("t5_noerr", 32'(error), 0);
        repeat (15) step();
        chk("t5_idle_15", 32'(idle), 0);
        step();
        chk("t5_idle_16", 32'(idle), 1);
        #3 reset_n = 1'b0;
        #1 chk("t5_async_idle", 32'(idle), 0);
        reset_n = 1'b1;

        // 6: saturation at CNT_W=2, asynchronous reset, no residual settle count
        ar2[0] = 1'b1; repeat (3) step();
        chk("t6_out3", 32'(outstanding2), 3);
        chk("t6_noerr", 32'(error2), 0);
        step(); ar2 = '0;
        chk("t6_sat", 32'(outstanding2), 3);
        chk("t6_err", 32'(error2), 1);
        chk("t6_errport", 32'(err_port2), 0);
        #3 rst2_n = 1'b0;
        #1;
        chk("t6_async_out", 32'(outstanding2), 0);
        chk("t6_async_err", 32'(error2), 0);
        rst2_n = 1'b1;
        repeat (8) step();
        #3 rst2_n = 1'b0;
        #1 chk("t6_settle_rst_idle", 32'(idle2), 0);
        rst2_n = 1'b1;
        repeat (15) step();
        chk("t6_idle_15", 32'(idle2), 0);
        step();
        chk("t6_idle_16", 32'(idle2), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
